// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that owns the select of a shared 8:1 mux path, with a per-owner hold limit.
// Optional ARB_PRIO7_EN: requester 7 wins every arbitration point at which it is requesting.
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] BUSY      = 1'b1;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  logic [0:0] state;
  logic [2:0] last;
  logic [3:0] hold_cnt;
  logic       rel;
  logic       arb_point;
  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;

  // While busy, sel always holds the owner's index.
  always_comb begin
    rel       = (state == BUSY) && (!req[sel] || (hold_cnt == HOLD_LAST));
    arb_point = (state == IDLE) || rel;
  end

  // Scan from last+1 with wrap; the offset of 8 lands back on last, so the owner is scanned last.
  always_comb begin
    found  = 1'b0;
    winner = last;
    idx    = last;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
`ifdef ARB_PRIO7_EN
    if (req[7]) begin
      found  = 1'b1;
      winner = 3'd7;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      last     <= 3'd7;
      hold_cnt <= '0;
    end else if (arb_point) begin
      if (found) begin
        state    <= BUSY;
        grant    <= 8'd1 << winner;
        sel      <= winner;
        last     <= winner;
        hold_cnt <= '0;
        busy     <= 1'b1;
      end else begin
        state    <= IDLE;
        grant    <= '0;
        busy     <= 1'b0;
        hold_cnt <= '0;
      end
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: three instances (HOLD_MAX 4, 1, 2) share req/reset
// and are compared against an ownership-level reference model.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt    [3];
  logic [2:0] sel_o  [3];
  logic       busy_o [3];

  int hold_of [3];
  int owner   [3];
  int lastm   [3];
  int held    [3];
  int selm    [3];

  int checks;
  int errors;

  typedef struct packed {
    logic [2:0][7:0] g;
    logic [2:0][2:0] s;
    logic [2:0]      b;
  } exp_t;

  exp_t expq [$];
  exp_t e;

  mux_sel_arbiter #(.HOLD_MAX(4)) u_h4 (
    .clk(clk), .reset(reset), .req(req), .grant(gnt[0]), .sel(sel_o[0]), .busy(busy_o[0]));
  mux_sel_arbiter #(.HOLD_MAX(1)) u_h1 (
    .clk(clk), .reset(reset), .req(req), .grant(gnt[1]), .sel(sel_o[1]), .busy(busy_o[1]));
  mux_sel_arbiter #(.HOLD_MAX(2)) u_h2 (
    .clk(clk), .reset(reset), .req(req), .grant(gnt[2]), .sel(sel_o[2]), .busy(busy_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      owner[i] = -1;
      lastm[i] = 7;
      held[i]  = 0;
      selm[i]  = 0;
    end
  endtask

  // Ownership model: an owner keeps the path for at most HOLD_MAX cycles and only while requesting.
  task automatic model_step(input logic [7:0] r);
    for (int i = 0; i < 3; i++) begin
      if (owner[i] < 0 || !r[owner[i]] || held[i] >= hold_of[i]) begin
        int w;
        w = -1;
`ifdef ARB_PRIO7_EN
        if (r[7]) w = 7;
`endif
        for (int k = 1; k <= 8 && w < 0; k++)
          if (r[(lastm[i] + k) % 8]) w = (lastm[i] + k) % 8;
        if (w >= 0) begin
          owner[i] = w;
          lastm[i] = w;
          selm[i]  = w;
          held[i]  = 1;
        end else begin
          owner[i] = -1;
        end
      end else begin
        held[i]++;
      end
    end
  endtask

  task automatic push_expected();
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      x.g[i] = (owner[i] < 0) ? 8'h00 : (8'd1 << owner[i]);
      x.s[i] = 3'(selm[i]);
      x.b[i] = (owner[i] >= 0);
    end
    expq.push_back(x);
  endtask

  task automatic applyStimulus(input logic [7:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
    push_expected();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_grant", gnt[i], 8'h00);
      checkOutput("rst_sel", {5'b0, sel_o[i]}, 8'h00);
      checkOutput("rst_busy", {7'b0, busy_o[i]}, 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;
    req = 8'h00;
    model_step(8'h00);
    push_expected();
  endtask

  // Monitor: compares each registered output against the next queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        for (int i = 0; i < 3; i++) begin
          checkOutput($sformatf("grant_h%0d", hold_of[i]), gnt[i], e.g[i]);
          checkOutput($sformatf("sel_h%0d", hold_of[i]), {5'b0, sel_o[i]}, {5'b0, e.s[i]});
          checkOutput($sformatf("busy_h%0d", hold_of[i]), {7'b0, busy_o[i]}, {7'b0, e.b[i]});
          checkOutput("onehot0", {7'b0, $onehot0(gnt[i])}, 8'h01);
          checkOutput("busy_eq_or", {7'b0, busy_o[i]}, {7'b0, |gnt[i]});
          if (busy_o[i]) begin
            logic [2:0] gi;
            gi = 3'd0;
            for (int b = 0; b < 8; b++) if (gnt[i][b]) gi = 3'(b);
            checkOutput("sel_idx", {5'b0, sel_o[i]}, {5'b0, gi});
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] r;
    hold_of[0] = 4;
    hold_of[1] = 1;
    hold_of[2] = 2;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req    = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    repeat (10) applyStimulus(8'h01);
    repeat (12) applyStimulus(8'hFF);

    do_reset();
    applyStimulus(8'h04);
    applyStimulus(8'h24);
    applyStimulus(8'h20);
    applyStimulus(8'h00);
    applyStimulus(8'h00);

    applyStimulus(8'h40);
    applyStimulus(8'h40);
    do_reset();
    repeat (4) applyStimulus(8'h41);

    do_reset();
    repeat (8) applyStimulus(8'h81);

    r = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      if ($urandom_range(0, 9) < 3) r = 8'($urandom);
      else if ($urandom_range(0, 9) == 0) r = r & 8'($urandom);
      applyStimulus(r);
    end

    repeat (4) @(negedge clk);
    checkOutput("queue_drain", 8'(expq.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
